// File: rtl/sdram_resp.sv
// Memory-side responder for the SDRAM_IF command/data protocol: register-array
// memory with late-write data phase, fixed-latency reads and saturating counters.
module sdram_resp #(
    parameter int          sd_a_width = 10,
    parameter int          mem_aw     = 6,
    parameter int          rd_lat     = 2,
    parameter logic [31:0] oor_data   = 32'hDEAD_BEEF
) (
    input  logic                  sdram_clk,
    input  logic                  sdram_rst_n,
    input  logic [sd_a_width-1:0] sd_A,
    input  logic                  sd_LD,
    input  logic                  sd_RW,
    input  logic [1:0]            sd_BWS,
    input  logic [31:0]           sd_DQ_in,
    output logic [31:0]           sd_DQ_out,
    output logic                  sd_DQ_oe,
    output logic [15:0]           rd_cnt,
    output logic [15:0]           wr_cnt,
    output logic [7:0]            err_cnt
);

    localparam int DEPTH = 1 << mem_aw;

    if (rd_lat < 1 || rd_lat > 4) begin : g_bad_rd_lat
        $error("sdram_resp: rd_lat must be in 1..4");
    end

    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt, input logic inc);
        return (inc && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] cnt, input logic inc);
        return (inc && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
    endfunction

    logic [31:0]       r_mem [DEPTH];

    logic              r_wr_pend;
    logic              r_wr_inr;
    logic [mem_aw-1:0] r_wr_addr;

    logic              r_rd_vld [rd_lat];
    logic [31:0]       r_rd_dat [rd_lat];

    logic              w_rd_cmd;
    logic              w_wr_cmd;
    logic              w_in_range;
    logic [mem_aw-1:0] w_addr;
    logic              w_commit;
    logic              w_fwd;
    logic [31:0]       w_lane_mask;
    logic [31:0]       w_mem_word;
    logic [31:0]       w_rd_word;

    assign w_rd_cmd    = sd_LD & sd_RW;
    assign w_wr_cmd    = sd_LD & ~sd_RW;
    assign w_in_range  = (sd_A[sd_a_width-1:mem_aw] == '0);
    assign w_addr      = sd_A[mem_aw-1:0];
    assign w_commit    = r_wr_pend & r_wr_inr;
    assign w_lane_mask = {{16{sd_BWS[1]}}, {16{sd_BWS[0]}}};
    assign w_mem_word  = r_mem[w_addr];

    // A read landing on the edge where a pending write commits sees the merged word.
    assign w_fwd       = w_commit && (r_wr_addr == w_addr);

    always_comb begin
        w_rd_word = w_mem_word;
        if (!w_in_range) begin
            w_rd_word = oor_data;
        end else if (w_fwd) begin
            w_rd_word = (sd_DQ_in & w_lane_mask) | (w_mem_word & ~w_lane_mask);
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (w_commit) begin
            if (sd_BWS[0]) r_mem[r_wr_addr][15:0]  <= sd_DQ_in[15:0];
            if (sd_BWS[1]) r_mem[r_wr_addr][31:16] <= sd_DQ_in[31:16];
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (w_wr_cmd) begin
            r_wr_addr <= w_addr;
            r_wr_inr  <= w_in_range;
        end
        r_rd_dat[0] <= w_rd_word;
        for (int k = 1; k < rd_lat; k++) begin
            r_rd_dat[k] <= r_rd_dat[k-1];
        end
    end

    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            r_wr_pend <= 1'b0;
            for (int k = 0; k < rd_lat; k++) begin
                r_rd_vld[k] <= 1'b0;
            end
            sd_DQ_out <= 32'h0;
            sd_DQ_oe  <= 1'b0;
            rd_cnt    <= 16'h0;
            wr_cnt    <= 16'h0;
            err_cnt   <= 8'h0;
        end else begin
            r_wr_pend   <= w_wr_cmd;
            r_rd_vld[0] <= w_rd_cmd;
            for (int k = 1; k < rd_lat; k++) begin
                r_rd_vld[k] <= r_rd_vld[k-1];
            end
            // Last stage drives the bus; data holds its last value between reads.
            sd_DQ_oe <= r_rd_vld[rd_lat-1];
            if (r_rd_vld[rd_lat-1]) begin
                sd_DQ_out <= r_rd_dat[rd_lat-1];
            end
            rd_cnt  <= sat_inc16(rd_cnt, w_rd_cmd);
            wr_cnt  <= sat_inc16(wr_cnt, w_wr_cmd);
            err_cnt <= sat_inc8(err_cnt, sd_LD && !w_in_range);
        end
    end

endmodule

// File: tb/tb_sdram_resp.sv
// Bench for sdram_resp: directed literal scenarios plus randomized traffic checked
// every cycle against a behavioural memory model.
module tb_sdram_resp;

    localparam int          AW  = 10;
    localparam int          MAW = 6;
    localparam int          LAT = 2;
    localparam logic [31:0] OOR = 32'hDEAD_BEEF;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [AW-1:0] a   = '0;
    logic        ld    = 1'b0;
    logic        rw    = 1'b0;
    logic [1:0]  bws   = 2'b00;
    logic [31:0] dq    = 32'h0;
    logic [31:0] dq_out;
    logic        dq_oe;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
    logic [7:0]  err_cnt;

    int checks   = 0;
    int failures = 0;

    sdram_resp #(.sd_a_width(AW), .mem_aw(MAW), .rd_lat(LAT), .oor_data(OOR)) dut (
        .sdram_clk  (clk),
        .sdram_rst_n(rst_n),
        .sd_A       (a),
        .sd_LD      (ld),
        .sd_RW      (rw),
        .sd_BWS     (bws),
        .sd_DQ_in   (dq),
        .sd_DQ_out  (dq_out),
        .sd_DQ_oe   (dq_oe),
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: word array, one pending write, and a ring of expected bus cycles.
    logic [31:0] m_mem [64];
    bit          m_known [64];
    bit          m_pend = 1'b0;
    bit          m_pinr = 1'b0;
    logic [5:0]  m_pa   = '0;
    bit          e_vld [8];
    bit          e_kn  [8];
    logic [31:0] e_dat [8];
    int          cyc   = 0;
    int          m_rd  = 0;
    int          m_wr  = 0;
    int          m_err = 0;
    logic [31:0] mv;
    bit          mkn;
    bit          minr;
    int          slot;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 1'b0;
            for (int i = 0; i < 8; i++) e_vld[i] = 1'b0;
            m_rd = 0; m_wr = 0; m_err = 0;
        end else begin
            e_vld[cyc % 8] = 1'b0;
            cyc++;
            minr = (a[AW-1:MAW] == '0);
            if (ld) begin
                if (rw) begin if (m_rd < 65535) m_rd++; end
                else    begin if (m_wr < 65535) m_wr++; end
                if (!minr && m_err < 255) m_err++;
            end
            if (ld && rw) begin
                slot = (cyc + LAT) % 8;
                if (!minr) begin
                    mv = OOR; mkn = 1'b1;
                end else begin
                    mv  = m_mem[a[MAW-1:0]];
                    mkn = m_known[a[MAW-1:0]];
                    if (m_pend && m_pinr && m_pa == a[MAW-1:0]) begin
                        for (int l = 0; l < 2; l++)
                            if (bws[l]) mv[16*l +: 16] = dq[16*l +: 16];
                        if (bws == 2'b11) mkn = 1'b1;
                    end
                end
                e_vld[slot] = 1'b1; e_kn[slot] = mkn; e_dat[slot] = mv;
            end
            if (m_pend && m_pinr) begin
                for (int l = 0; l < 2; l++)
                    if (bws[l]) m_mem[m_pa][16*l +: 16] = dq[16*l +: 16];
                if (bws == 2'b11) m_known[m_pa] = 1'b1;
            end
            m_pend = ld && !rw;
            m_pa   = a[MAW-1:0];
            m_pinr = minr;
        end
    end

    always @(negedge clk) begin
        int idx;
        idx = cyc % 8;
        chk("oe", {31'b0, dq_oe}, {31'b0, e_vld[idx]});
        if (e_vld[idx] && e_kn[idx]) chk("rdata", dq_out, e_dat[idx]);
        chk("rd_cnt", {16'b0, rd_cnt}, m_rd);
        chk("wr_cnt", {16'b0, wr_cnt}, m_wr);
        chk("err_cnt", {24'b0, err_cnt}, m_err);
    end

    task automatic step(input logic l, input logic r, input logic [AW-1:0] ad,
                        input logic [1:0] b, input logic [31:0] d);
        ld = l; rw = r; a = ad; bws = b; dq = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 2'b00, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) m_known[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);
        chk("rst_oe", {31'b0, dq_oe}, 32'h0);
        chk("rst_dout", dq_out, 32'h0);
        chk("rst_rd_cnt", {16'b0, rd_cnt}, 32'h0);
        chk("rst_wr_cnt", {16'b0, wr_cnt}, 32'h0);
        chk("rst_err_cnt", {24'b0, err_cnt}, 32'h0);

        // Full write then read
        step(1, 0, 10'd3, 2'b00, 32'h0);
        step(0, 0, 10'd0, 2'b11, 32'h1234_5678);
        idle(1);
        step(1, 1, 10'd3, 2'b00, 32'h0);
        idle(1);
        chk("lat1_oe_early", {31'b0, dq_oe}, 32'h0);
        idle(1);
        chk("wr_rd_data", dq_out, 32'h1234_5678);
        chk("wr_rd_oe", {31'b0, dq_oe}, 32'h1);
        chk("wr_cnt_1", {16'b0, wr_cnt}, 32'd1);
        chk("rd_cnt_1", {16'b0, rd_cnt}, 32'd1);

        // Partial lane write
        step(1, 0, 10'd3, 2'b00, 32'h0);
        step(0, 0, 10'd0, 2'b01, 32'hAAAA_BBBB);
        step(1, 1, 10'd3, 2'b00, 32'h0);
        idle(2);
        chk("partial", dq_out, 32'h1234_BBBB);

        // Forwarding with back-to-back writes
        step(1, 0, 10'd5, 2'b00, 32'h0);
        step(1, 0, 10'd5, 2'b11, 32'h0000_1111);
        step(1, 1, 10'd5, 2'b10, 32'hCAFE_F00D);
        idle(2);
        chk("forward", dq_out, 32'hCAFE_1111);
        step(1, 1, 10'd5, 2'b00, 32'h0);
        idle(2);
        chk("after_fwd", dq_out, 32'hCAFE_1111);

        // Out of range
        step(1, 0, 10'd0, 2'b00, 32'h0);
        step(1, 0, 10'h040, 2'b11, 32'h0BAD_F00D);
        step(1, 1, 10'h040, 2'b11, 32'h5555_5555);
        idle(2);
        chk("oor_data", dq_out, OOR);
        chk("oor_err_cnt", {24'b0, err_cnt}, 32'd2);
        step(1, 1, 10'd0, 2'b00, 32'h0);
        idle(2);
        chk("oor_word0", dq_out, 32'h0BAD_F00D);

        // Streaming
        for (int i = 0; i < 9; i++)
            step(i < 8, 0, 10'(i), (i > 0) ? 2'b11 : 2'b00, 32'h100 + 32'(i) - 32'd1);
        for (int i = 0; i < 10; i++) begin
            step(i < 8, 1, 10'(i), 2'b00, 32'h0);
            if (i >= 2) begin
                chk("stream_oe", {31'b0, dq_oe}, 32'h1);
                chk("stream_data", dq_out, 32'h100 + 32'(i) - 32'd2);
            end
        end
        idle(1);

        // Reset with reads in flight
        step(1, 1, 10'd0, 2'b00, 32'h0);
        step(1, 1, 10'd1, 2'b00, 32'h0);
        step(1, 1, 10'd2, 2'b00, 32'h0);
        chk("pre_rst_oe", {31'b0, dq_oe}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_drop_oe", {31'b0, dq_oe}, 32'h0);
        ld = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(4);

        // Pending write dropped by reset
        step(1, 0, 10'd7, 2'b00, 32'h0);
        ld = 1'b0; bws = 2'b11; dq = 32'h0BAD_0BAD;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        step(1, 1, 10'd7, 2'b00, 32'h0);
        idle(2);
        chk("wr_dropped", dq_out, 32'h107);

        // Prefill then random traffic
        for (int i = 0; i < 65; i++)
            step(i < 64, 0, 10'(i), (i > 0) ? 2'b11 : 2'b00, $urandom);
        for (int i = 0; i < 2000; i++) begin
            logic [AW-1:0] ra;
            int sel;
            sel = $urandom_range(0, 3);
            if (sel == 0)      ra = AW'($urandom_range(0, 1023));
            else if (sel == 1) ra = AW'($urandom_range(0, 3));
            else               ra = AW'($urandom_range(0, 63));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra,
                 2'($urandom_range(0, 3)), $urandom);
        end
        idle(6);
        chk("err_sat", {24'b0, err_cnt}, 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
